// File: rtl/tlul_prog_loader.sv
// Byte-stream program loader: assembles little-endian words and writes them over TL-UL, then releases the core.
// Optional macro PROG_LOADER_CKSUM_EN adds a trailing 32-bit check word compared against the sum of written words.

package prim_mubi_pkg;
  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;
endpackage

package ibex_pkg;
  typedef enum logic [3:0] {
    IbexMuBiOn  = 4'b0101,
    IbexMuBiOff = 4'b1010
  } ibex_mubi_t;
endpackage

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0]            rsvd;
    prim_mubi_pkg::mubi4_t instr_type;
    logic [6:0]            cmd_intg;
    logic [6:0]            data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: prim_mubi_pkg::MuBi4False,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
  parameter int unsigned MAX_WORDS = 32,
  parameter logic [31:0] SENTINEL  = 32'h0000_0FFF,
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_i,
  output logic                       byte_ready_o,
  output tlul_pkg::tl_h2d_t          tl_o,
  input  tlul_pkg::tl_d2h_t          tl_i,
  output ibex_pkg::ibex_mubi_t       fetch_enable_o,
  output prim_mubi_pkg::mubi4_t      en_ifetch_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           word_cnt_o
);

  typedef enum logic [2:0] {
    ST_ASSEMBLE,
    ST_REQ,
    ST_RSP,
    ST_DONE,
    ST_ERR
`ifdef PROG_LOADER_CKSUM_EN
    , ST_CKSUM
`endif
  } state_e;

  state_e             state_reg, state_next;
  logic [1:0]         idx_reg;
  logic [23:0]        asm_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        data_reg;
  logic               loaded_reg;
`ifdef PROG_LOADER_CKSUM_EN
  logic [31:0]        sum_reg;
`endif

  logic        byte_fire;
  logic        last_byte;
  logic [31:0] full_word;
  logic        cnt_full;
  logic        capture;
  logic        d_ok;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign last_byte = byte_fire && (idx_reg == 2'd3);
  assign full_word = {byte_i, asm_reg};
  assign cnt_full  = (word_cnt_reg == CNT_W'(MAX_WORDS));
  assign capture   = (state_reg == ST_ASSEMBLE) && last_byte && !cnt_full;
  assign d_ok      = (state_reg == ST_RSP) && tl_i.d_valid && !tl_i.d_error;

  always_comb begin
    state_next   = state_reg;
    byte_ready_o = 1'b0;
    unique case (state_reg)
      ST_ASSEMBLE: begin
        byte_ready_o = 1'b1;
        if (last_byte) begin
          state_next = cnt_full ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (tl_i.a_ready) state_next = ST_RSP;
      end
      ST_RSP: begin
        // d_valid is only meaningful here; responses elsewhere are dropped.
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            state_next = ST_ERR;
          end else if (data_reg == SENTINEL) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_next = ST_CKSUM;
`else
            state_next = ST_DONE;
`endif
          end else begin
            state_next = ST_ASSEMBLE;
          end
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        byte_ready_o = 1'b1;
        if (last_byte) begin
          state_next = (full_word == sum_reg) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: state_next = ST_DONE;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_ASSEMBLE;
      idx_reg      <= 2'd0;
      asm_reg      <= '0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      loaded_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (byte_fire) begin
        idx_reg <= idx_reg + 2'd1;
        for (int i = 0; i < 3; i++) begin
          if (idx_reg == 2'(i)) asm_reg[8*i +: 8] <= byte_i;
        end
      end
      // Request fields are latched once per word so they stay put while a_ready is low.
      if (capture) begin
        data_reg   <= full_word;
        addr_reg   <= BASE_ADDR + (32'(word_cnt_reg) << 2);
        loaded_reg <= 1'b1;
      end
      if (d_ok) word_cnt_reg <= word_cnt_reg + CNT_W'(1);
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_reg <= '0;
    end else if (d_ok) begin
      sum_reg <= sum_reg + data_reg;
    end
  end
`endif

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_reg == ST_REQ);
    tl_o.a_opcode  = tlul_pkg::PutFullData;
    tl_o.a_address = addr_reg;
    tl_o.a_data    = data_reg;
    tl_o.d_ready   = 1'b1;
    if (loaded_reg) begin
      tl_o.a_size  = 2'd2;
      tl_o.a_mask  = 4'hF;
      tl_o.a_user  = tlul_pkg::TL_A_USER_DEFAULT;
    end
  end

  assign done_o         = (state_reg == ST_DONE);
  assign err_o          = (state_reg == ST_ERR);
  assign fetch_enable_o = done_o ? ibex_pkg::IbexMuBiOn : ibex_pkg::IbexMuBiOff;
  assign en_ifetch_o    = done_o ? prim_mubi_pkg::MuBi4True : prim_mubi_pkg::MuBi4False;
  assign word_cnt_o     = word_cnt_reg;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_data, tl_i.d_user};

endmodule

// File: tb/tb_tlul_prog_loader.sv
// Directed bench for tlul_prog_loader with a simple TL-UL device model answering one cycle after each A handshake.
// Check-word steps are included when PROG_LOADER_CKSUM_EN is defined.
module tb_tlul_prog_loader;
  import tlul_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_d = 8'h00;
  logic                  byte_ready;
  tl_h2d_t               tl_o;
  tl_d2h_t               tl_i;
  ibex_pkg::ibex_mubi_t  fetch_enable;
  prim_mubi_pkg::mubi4_t en_ifetch;
  logic                  done;
  logic                  err;
  logic [5:0]            word_cnt;

  logic a_ready_drv = 1'b1;
  logic d_valid_drv = 1'b0;
  logic d_error_drv = 1'b0;

  int err_at   = 0;
  int wr_total = 0;
  int wr_base  = 0;
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  always_comb begin
    tl_i         = '0;
    tl_i.a_ready = a_ready_drv;
    tl_i.d_valid = d_valid_drv;
    tl_i.d_error = d_error_drv;
  end

  tlul_prog_loader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .byte_valid_i   (byte_valid),
    .byte_i         (byte_d),
    .byte_ready_o   (byte_ready),
    .tl_o           (tl_o),
    .tl_i           (tl_i),
    .fetch_enable_o (fetch_enable),
    .en_ifetch_o    (en_ifetch),
    .done_o         (done),
    .err_o          (err),
    .word_cnt_o     (word_cnt)
  );

  // Device model: log each A handshake mid-cycle, answer with d_valid during the following cycle.
  always begin : device
    logic hs;
    logic herr;
    int   slot;
    @(negedge clk);
    hs   = !rst && tl_o.a_valid && a_ready_drv;
    herr = 1'b0;
    if (hs) begin
      slot = (wr_total - wr_base) & 255;
      wr_addr[slot] = tl_o.a_address;
      wr_data[slot] = tl_o.a_data;
      wr_total++;
      herr = (err_at != 0) && ((wr_total - wr_base) == err_at);
      $display("[TB] write #%0d addr=%h data=%h d_error=%0b", wr_total - wr_base,
               tl_o.a_address, tl_o.a_data, herr);
    end
    @(posedge clk);
    #1;
    d_valid_drv = hs;
    d_error_drv = herr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr_base = wr_total;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n          = 0;
    byte_valid = 1'b1;
    byte_d     = b;
    @(negedge clk);
    while (!byte_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("byte_accept_timeout", {31'b0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic finish_image(input logic [31:0] sum);
`ifdef PROG_LOADER_CKSUM_EN
    send_word(sum);
`else
    if (sum == 32'hFFFF_FFFF) $display("[TB] unexpected checksum argument");
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) check("end_timeout", {31'b0, done | err}, 32'd1);
  endtask

  task automatic check_done(input string tag, input int cnt);
    check({tag, "_done"},   {31'b0, done}, 32'd1);
    check({tag, "_err"},    {31'b0, err},  32'd0);
    check({tag, "_fetch"},  {28'b0, fetch_enable}, {28'b0, ibex_pkg::IbexMuBiOn});
    check({tag, "_ifetch"}, {28'b0, en_ifetch}, {28'b0, prim_mubi_pkg::MuBi4True});
    check({tag, "_cnt"},    {26'b0, word_cnt}, 32'(cnt));
  endtask

  task automatic check_err(input string tag, input int cnt);
    check({tag, "_err"},    {31'b0, err},  32'd1);
    check({tag, "_done"},   {31'b0, done}, 32'd0);
    check({tag, "_fetch"},  {28'b0, fetch_enable}, {28'b0, ibex_pkg::IbexMuBiOff});
    check({tag, "_ifetch"}, {28'b0, en_ifetch}, {28'b0, prim_mubi_pkg::MuBi4False});
    check({tag, "_cnt"},    {26'b0, word_cnt}, 32'(cnt));
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_a_valid",  {31'b0, tl_o.a_valid}, 32'd0);
    check("rst_d_ready",  {31'b0, tl_o.d_ready}, 32'd1);
    check("rst_addr",     tl_o.a_address, 32'h0);
    check("rst_data",     tl_o.a_data, 32'h0);
    check("rst_mask",     {28'b0, tl_o.a_mask}, 32'h0);
    check("rst_byte_rdy", {31'b0, byte_ready}, 32'd1);
    check("rst_cnt",      {26'b0, word_cnt}, 32'd0);
    check("rst_done",     {31'b0, done}, 32'd0);
    check("rst_err",      {31'b0, err}, 32'd0);
    check("rst_fetch",    {28'b0, fetch_enable}, {28'b0, ibex_pkg::IbexMuBiOff});
    check("rst_ifetch",   {28'b0, en_ifetch}, {28'b0, prim_mubi_pkg::MuBi4False});

    // Basic two-word image with a_ready tied high
    a_ready_drv = 1'b1;
    send_word(32'h0000_0513);
    check("t1_a_valid_lat", {31'b0, tl_o.a_valid}, 32'd1);
    check("t1_addr",   tl_o.a_address, 32'h0000_0080);
    check("t1_data",   tl_o.a_data, 32'h0000_0513);
    check("t1_opcode", {29'b0, tl_o.a_opcode}, {29'b0, PutFullData});
    check("t1_size",   {30'b0, tl_o.a_size}, 32'd2);
    check("t1_mask",   {28'b0, tl_o.a_mask}, 32'hF);
    send_word(32'h0000_0FFF);
    finish_image(32'h0000_1512);
    wait_end();
    check("t1_nwr",   32'(wr_total - wr_base), 32'd2);
    check("t1_addr0", wr_addr[0], 32'h0000_0080);
    check("t1_data0", wr_data[0], 32'h0000_0513);
    check("t1_addr1", wr_addr[1], 32'h0000_0084);
    check("t1_data1", wr_data[1], 32'h0000_0FFF);
    check_done("t1", 2);
    check("t1_byte_rdy", {31'b0, byte_ready}, 32'd0);

    // a_ready held low for 5 cycles; a byte is offered meanwhile and must survive
    do_reset();
    a_ready_drv = 1'b0;
    send_word(32'h1122_3344);
    byte_valid = 1'b1;
    byte_d     = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'b0, tl_o.a_valid}, 32'd1);
      check("t2_hold_addr",  tl_o.a_address, 32'h0000_0080);
      check("t2_hold_data",  tl_o.a_data, 32'h1122_3344);
      check("t2_hold_brdy",  {31'b0, byte_ready}, 32'd0);
    end
    check("t2_hold_nwr", 32'(wr_total - wr_base), 32'd0);
    @(posedge clk);
    #1;
    a_ready_drv = 1'b1;
    send_word(32'h0000_0FFF);
    finish_image(32'h1122_4343);
    wait_end();
    check("t2_nwr",   32'(wr_total - wr_base), 32'd2);
    check("t2_data0", wr_data[0], 32'h1122_3344);
    check("t2_addr1", wr_addr[1], 32'h0000_0084);
    check("t2_data1", wr_data[1], 32'h0000_0FFF);
    check_done("t2", 2);

    // d_error on the second response
    do_reset();
    err_at = 2;
    send_word(32'h0000_0513);
    send_word(32'h0000_0FFF);
    wait_end();
    check_err("t3", 1);
    byte_valid = 1'b1;
    byte_d     = 8'h55;
    repeat (10) @(negedge clk);
    check("t3_byte_rdy", {31'b0, byte_ready}, 32'd0);
    check("t3_nwr", 32'(wr_total - wr_base), 32'd2);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    err_at     = 0;

    // Overflow: 32 words accepted, the 33rd aborts
    do_reset();
    for (int i = 1; i <= 33; i++) send_word(32'(i));
    wait_end();
    check("t4_nwr",    32'(wr_total - wr_base), 32'd32);
    check("t4_addr0",  wr_addr[0], 32'h0000_0080);
    check("t4_addr31", wr_addr[31], 32'h0000_00FC);
    check("t4_data31", wr_data[31], 32'h0000_0020);
    check_err("t4", 32);

    // Sentinel as the 32nd word is legal
    do_reset();
    for (int i = 1; i <= 31; i++) send_word(32'(i));
    send_word(32'h0000_0FFF);
    finish_image(32'h0000_11EF);
    wait_end();
    check("t4b_addr31", wr_addr[31], 32'h0000_00FC);
    check("t4b_data31", wr_data[31], 32'h0000_0FFF);
    check_done("t4b", 32);

    // Reset while a request is stalled
    do_reset();
    a_ready_drv = 1'b0;
    send_word(32'hDEAD_BEEF);
    @(negedge clk);
    check("t5_pre_valid", {31'b0, tl_o.a_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_a_valid",  {31'b0, tl_o.a_valid}, 32'd0);
    check("t5_cnt",      {26'b0, word_cnt}, 32'd0);
    check("t5_byte_rdy", {31'b0, byte_ready}, 32'd1);
    wr_base     = wr_total;
    a_ready_drv = 1'b1;
    send_word(32'h0000_0513);
    send_word(32'h0000_0FFF);
    finish_image(32'h0000_1512);
    wait_end();
    check("t5_nwr",   32'(wr_total - wr_base), 32'd2);
    check("t5_addr0", wr_addr[0], 32'h0000_0080);
    check("t5_data0", wr_data[0], 32'h0000_0513);
    check_done("t5", 2);

`ifdef PROG_LOADER_CKSUM_EN
    // Wrong check word
    do_reset();
    send_word(32'h0000_0513);
    send_word(32'h0000_0FFF);
    send_word(32'h0000_1513);
    wait_end();
    check("t6_nwr", 32'(wr_total - wr_base), 32'd2);
    check_err("t6", 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
